z80_irq_ctrl: RTL and testbench

//  Shares the single Z80 /INT line between NUM_SRC level-sensitive interrupt sources (16550 U_INT, timers, ...).

---
 rtl/z80_irq_ctrl_pkg.sv | 35 +++
 rtl/z80_irq_ctrl_if.sv | 19 +
 rtl/z80_irq_ctrl_sync.sv | 33 +++
 rtl/z80_irq_ctrl.sv | 145 ++++++++++++++
 tb/tb_z80_irq_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/z80_irq_ctrl_pkg.sv
// Shared constants, FSM state type and helpers for the Z80 interrupt controller.
//   DEF_*_PORT : default IO addresses (A[7:0]) of the three registers
//   OP_ED/OP_4D: the two opcode bytes that form RETI
//   irq_state_e: controller FSM states
//   prio_enc   : fixed-priority encoder, index 0 wins
//   stat_word  : STAT register layout {in_svc, svc_id[1:0], 0, pend[3:0]}
package z80_irq_ctrl_pkg;
  localparam logic [7:0] DEF_VEC_PORT  = 8'h14;
  localparam logic [7:0] DEF_MASK_PORT = 8'h15;
  localparam logic [7:0] DEF_STAT_PORT = 8'h16;

  localparam logic [7:0] OP_ED = 8'hED;
  localparam logic [7:0] OP_4D = 8'h4D;

  localparam int STAT_IN_SVC = 7;
  localparam int STAT_SVC_LO = 5;
  localparam int STAT_PEND_LO = 0;

  typedef enum logic [1:0] {ST_IDLE, ST_ASSERT, ST_ACK, ST_SERVICE} irq_state_e;

  // Scan from the top down so the lowest set index is the last one written.
  function automatic logic [1:0] prio_enc(input logic [3:0] r);
    prio_enc = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (r[i]) prio_enc = 2'(i);
  endfunction

  function automatic logic [7:0] stat_word(input logic in_svc, input logic [1:0] svc_id,
                                           input logic [3:0] pend);
    stat_word = '0;
    stat_word[STAT_IN_SVC] = in_svc;
    stat_word[STAT_SVC_LO +: 2] = svc_id;
    stat_word[STAT_PEND_LO +: 4] = pend;
  endfunction
endpackage

// File: rtl/z80_irq_ctrl_if.sv
// Z80 bus as seen by the interrupt controller.
//   IORQ/MREQ/M1/RD/WR : raw active-low strobes from the CPU
//   A_L, D_IN          : low address byte and data bus (read side)
//   D_OUT, D_OE        : data to the CPU and its drive enable
//   INT                : Z80 /INT, active-low
// master = CPU/bus side, slave = controller.
interface z80_irq_ctrl_if;
  logic       IORQ, MREQ, M1, RD, WR;
  logic [7:0] A_L;
  logic [7:0] D_IN;
  logic [7:0] D_OUT;
  logic       D_OE;
  logic       INT;

  modport master (output IORQ, MREQ, M1, RD, WR, A_L, D_IN,
                  input  D_OUT, D_OE, INT);
  modport slave  (input  IORQ, MREQ, M1, RD, WR, A_L, D_IN,
                  output D_OUT, D_OE, INT);
endinterface

// File: rtl/z80_irq_ctrl_sync.sv
// Two-flop synchroniser with a third delayed copy for edge detection.
//   clk   : sampling clock (negedge, like the memory mapper)
//   rst_n : async active-low reset, loads RST_VAL into every stage
//   din   : asynchronous inputs
//   s     : synchronised value
//   d     : s delayed by one clock (rise = s & ~d, fall = ~s & d)
module z80_irq_ctrl_sync #(
  parameter int   W       = 1,
  parameter logic RST_VAL = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] s,
  output logic [W-1:0] d
);
  logic [W-1:0] s1, s2, s3;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= {W{RST_VAL}};
      s2 <= {W{RST_VAL}};
      s3 <= {W{RST_VAL}};
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign s = s2;
  assign d = s3;
endmodule

// File: rtl/z80_irq_ctrl.sv
// Shares the Z80 /INT line between NUM_SRC level-sensitive sources, supplies
// an IM2 vector during the acknowledge cycle and tracks service until RETI or
// an EOI write.
//   CLK_24MHz : system clock, all flops on the falling edge
//   RES       : async reset, active-low
//   IRQ       : source requests, active-high level, asynchronous
//   bus       : Z80 strobes, address, data in/out and /INT
// Registers: VEC_PORT (vector base, R/W), MASK_PORT (enable mask, R/W),
// STAT_PORT (read status, any write = EOI).
module z80_irq_ctrl
  import z80_irq_ctrl_pkg::*;
#(
  parameter int         NUM_SRC   = 4,
  parameter logic [7:0] VEC_PORT  = DEF_VEC_PORT,
  parameter logic [7:0] MASK_PORT = DEF_MASK_PORT,
  parameter logic [7:0] STAT_PORT = DEF_STAT_PORT
) (
  input  logic               CLK_24MHz,
  input  logic               RES,
  input  logic [NUM_SRC-1:0] IRQ,
  z80_irq_ctrl_if.slave      bus
);
  localparam logic [3:0] SRC_BITS = 4'((1 << NUM_SRC) - 1);

  logic [4:0] stb_s, stb_d;
  logic [NUM_SRC-1:0] irq_s, irq_d;

  z80_irq_ctrl_sync #(.W(5), .RST_VAL(1'b1)) u_stb_sync (
    .clk(CLK_24MHz), .rst_n(RES),
    .din({bus.IORQ, bus.MREQ, bus.M1, bus.RD, bus.WR}),
    .s(stb_s), .d(stb_d));

  z80_irq_ctrl_sync #(.W(NUM_SRC), .RST_VAL(1'b0)) u_irq_sync (
    .clk(CLK_24MHz), .rst_n(RES), .din(IRQ), .s(irq_s), .d(irq_d));

  logic iorq_s, mreq_s, m1_s, rd_s, wr_s;
  logic iorq_d, mreq_d, m1_d, rd_d, wr_d;
  assign {iorq_s, mreq_s, m1_s, rd_s, wr_s} = stb_s;
  assign {iorq_d, mreq_d, m1_d, rd_d, wr_d} = stb_d;

  irq_state_e state, state_nx;
  logic       int_n, int_nx, latch_id;
  logic [7:0] vec_base, opc;
  logic [3:0] mask;
  logic [1:0] svc_id;
  logic       reti_ed;
  logic [3:0] irq4, held4, req, hold;
  logic       in_svc;

  always_comb begin
    irq4  = '0;
    held4 = '0;
    irq4[NUM_SRC-1:0]  = irq_s;
    held4[NUM_SRC-1:0] = irq_s | irq_d;
  end

  assign req    = irq4 & mask;
  // A pending INT is only withdrawn once the request has read low on two
  // consecutive samples, so a single-sample dip cannot abort it.
  assign hold   = held4 & mask;
  assign in_svc = (state == ST_SERVICE);

  // Strobe events in the clock domain.
  logic iowr_fall, iorq_rise, fetch_end, ack_s, fetch_cap;
  logic wr_vec, wr_mask, eoi, reti;
  assign iowr_fall = ~(iorq_s | wr_s) & (iorq_d | wr_d);
  assign iorq_rise = iorq_s & ~iorq_d;
  assign fetch_end = rd_s & ~rd_d & ~m1_d & ~mreq_d;
  assign ack_s     = ~m1_s & ~iorq_s & mreq_s;
  // Opcode byte is grabbed while the raw fetch strobes are low; the data is
  // gone by the time the synchronised RD rising edge arrives.
  assign fetch_cap = ~bus.RD & ~bus.MREQ & ~bus.M1;

  assign wr_vec  = iowr_fall && (bus.A_L == VEC_PORT);
  assign wr_mask = iowr_fall && (bus.A_L == MASK_PORT);
  assign eoi     = iowr_fall && (bus.A_L == STAT_PORT);
  assign reti    = fetch_end && reti_ed && (opc == OP_4D);

  always_comb begin
    state_nx = state;
    int_nx   = int_n;
    latch_id = 1'b0;
    unique case (state)
      ST_IDLE:
        if (|req && !in_svc) begin state_nx = ST_ASSERT; int_nx = 1'b0; end
      ST_ASSERT:
        if (~|hold) begin
          state_nx = ST_IDLE;
          int_nx   = 1'b1;
        end else if (ack_s) begin
          state_nx = ST_ACK;
          latch_id = 1'b1;
        end
      ST_ACK:
        if (iorq_rise) begin state_nx = ST_SERVICE; int_nx = 1'b1; end
      ST_SERVICE:
        if (reti || eoi) state_nx = ST_IDLE;
      default: begin state_nx = ST_IDLE; int_nx = 1'b1; end
    endcase
  end

  always_ff @(negedge CLK_24MHz or negedge RES) begin
    if (!RES) begin
      state    <= ST_IDLE;
      int_n    <= 1'b1;
      vec_base <= 8'h00;
      mask     <= 4'h0;
      svc_id   <= 2'd0;
      reti_ed  <= 1'b0;
      opc      <= 8'h00;
    end else begin
      state <= state_nx;
      int_n <= int_nx;
      if (latch_id)  svc_id   <= prio_enc(req);
      if (wr_vec)    vec_base <= bus.D_IN;
      if (wr_mask)   mask     <= bus.D_IN[3:0] & SRC_BITS;
      if (fetch_cap) opc      <= bus.D_IN;
      if (fetch_end) reti_ed  <= (opc == OP_ED);
    end
  end

  // Bus drive is combinational from the raw pins so the vector is on D
  // before the CPU samples it; RES gates both paths for an async release.
  logic       ack_drive, rd_hit;
  logic [7:0] rd_data;
  assign ack_drive = (state == ST_ACK) & ~bus.M1 & ~bus.IORQ;

  always_comb begin
    rd_hit  = 1'b0;
    rd_data = 8'h00;
    if (RES && !bus.IORQ && !bus.RD && bus.M1) begin
      if (bus.A_L == VEC_PORT) begin
        rd_hit = 1'b1; rd_data = vec_base;
      end else if (bus.A_L == MASK_PORT) begin
        rd_hit = 1'b1; rd_data = {4'h0, mask};
      end else if (bus.A_L == STAT_PORT) begin
        rd_hit = 1'b1; rd_data = stat_word(in_svc, svc_id, req);
      end
    end
  end

  assign bus.D_OE  = RES & (ack_drive | rd_hit);
  assign bus.D_OUT = ack_drive ? {vec_base[7:3], svc_id, 1'b0} : rd_data;
  assign bus.INT   = int_n;
endmodule

// File: tb/tb_z80_irq_ctrl.sv
// Directed bench for z80_irq_ctrl: register table plus hand-written
// interrupt / acknowledge / RETI / EOI / reset sequences.
module tb_z80_irq_ctrl;
  logic       clk = 1'b0;
  logic       res_n = 1'b0;
  logic [3:0] irq = 4'h0;

  z80_irq_ctrl_if bus();

  z80_irq_ctrl #(.NUM_SRC(4)) dut (
    .CLK_24MHz(clk), .RES(res_n), .IRQ(irq), .bus(bus));

  always #20 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic io_wr(input logic [7:0] addr, input logic [7:0] data);
    bus.A_L = addr; bus.D_IN = data;
    bus.IORQ = 1'b0; bus.WR = 1'b0;
    tick(5);
    bus.IORQ = 1'b1; bus.WR = 1'b1;
    tick(4);
  endtask

  task automatic rd_chk(input string name, input logic [7:0] addr, input logic [7:0] exp);
    logic oe;
    logic [7:0] data;
    bus.A_L = addr; bus.IORQ = 1'b0; bus.RD = 1'b0;
    tick(2);
    oe = bus.D_OE; data = bus.D_OUT;
    bus.IORQ = 1'b1; bus.RD = 1'b1;
    tick(3);
    check({name, "_oe"}, {7'd0, oe}, 8'd1);
    check(name, data, exp);
  endtask

  task automatic fetch(input logic [7:0] op);
    bus.D_IN = op;
    bus.M1 = 1'b0; bus.MREQ = 1'b0; bus.RD = 1'b0;
    tick(4);
    bus.RD = 1'b1; bus.MREQ = 1'b1; bus.M1 = 1'b1;
    tick(6);
  endtask

  // Full acknowledge cycle; reports whether D was ever driven and what.
  task automatic ack(output logic [7:0] vec, output logic oe_seen);
    vec = 8'h00; oe_seen = 1'b0;
    bus.M1 = 1'b0;
    tick(1);
    bus.IORQ = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (bus.D_OE) begin oe_seen = 1'b1; vec = bus.D_OUT; end
    end
    bus.IORQ = 1'b1; bus.M1 = 1'b1;
    tick(5);
  endtask

  // Cycles until INT reaches the wanted level; max+1 means timed out.
  task automatic wait_int(input logic lvl, input int max, output int cyc);
    cyc = max + 1;
    for (int i = 1; i <= max; i++) begin
      tick(1);
      if (bus.INT === lvl) begin cyc = i; break; end
    end
  endtask

  initial begin
    logic [7:0] v;
    logic       oe;
    int         cyc;

    bus.IORQ = 1'b1; bus.MREQ = 1'b1; bus.M1 = 1'b1; bus.RD = 1'b1; bus.WR = 1'b1;
    bus.A_L = 8'h00; bus.D_IN = 8'h00;

    tbl[0] = '{1'b0, 8'h14, 8'h00, 8'h00, "rst_vec"};
    tbl[1] = '{1'b0, 8'h15, 8'h00, 8'h00, "rst_mask"};
    tbl[2] = '{1'b0, 8'h16, 8'h00, 8'h00, "rst_stat"};
    tbl[3] = '{1'b1, 8'h14, 8'hA0, 8'h00, "wr_vec"};
    tbl[4] = '{1'b0, 8'h14, 8'h00, 8'hA0, "rd_vec_a0"};
    tbl[5] = '{1'b1, 8'h15, 8'hFF, 8'h00, "wr_mask"};
    tbl[6] = '{1'b0, 8'h15, 8'h00, 8'h0F, "rd_mask_0f"};
    tbl[7] = '{1'b1, 8'h14, 8'hA7, 8'h00, "wr_vec2"};
    tbl[8] = '{1'b0, 8'h14, 8'h00, 8'hA7, "rd_vec_a7"};

    // Reset state while held.
    tick(3);
    check("rst_int", {7'd0, bus.INT}, 8'd1);
    check("rst_oe", {7'd0, bus.D_OE}, 8'd0);
    check("rst_dout", bus.D_OUT, 8'h00);
    res_n = 1'b1;
    tick(3);

    // Masked source must not raise INT.
    irq = 4'b0001;
    tick(8);
    check("masked_int", {7'd0, bus.INT}, 8'd1);
    irq = 4'b0000;
    tick(4);

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].wr) io_wr(tbl[i].addr, tbl[i].data);
      else           rd_chk(tbl[i].name, tbl[i].addr, tbl[i].exp);
    end

    // Single source 2; vector base A7 -> {10100,10,0} = A4.
    irq = 4'b0100;
    wait_int(1'b0, 10, cyc);
    check("s2_int_lat", {7'd0, cyc <= 4}, 8'd1);
    ack(v, oe);
    check("s2_ack_oe", {7'd0, oe}, 8'd1);
    check("s2_vec", v, 8'hA4);
    check("s2_int_hi", {7'd0, bus.INT}, 8'd1);
    rd_chk("s2_stat", 8'h16, 8'hC4);   // in_svc=1, svc_id=2, pend=0100
    irq = 4'b0000;
    tick(4);
    io_wr(8'h16, 8'h00);
    rd_chk("s2_stat_eoi", 8'h16, 8'h40);
    check("s2_int_idle", {7'd0, bus.INT}, 8'd1);

    // Sources 1 and 3 together: 1 wins, RETI then lets 3 through.
    irq = 4'b1010;
    wait_int(1'b0, 10, cyc);
    check("s13_int_lat", {7'd0, cyc <= 4}, 8'd1);
    ack(v, oe);
    check("s1_vec", v, 8'hA2);
    rd_chk("s1_stat", 8'h16, 8'hAA);
    irq = 4'b1000;
    fetch(8'hED);
    fetch(8'h4D);
    rd_chk("s1_stat_reti", 8'h16, 8'h28);
    wait_int(1'b0, 10, cyc);
    check("s3_int_lat", {7'd0, cyc <= 4}, 8'd1);
    ack(v, oe);
    check("s3_vec", v, 8'hA6);
    irq = 4'b0000;
    fetch(8'hED);
    fetch(8'h4D);
    rd_chk("s3_stat_reti", 8'h16, 8'h60);

    // Request withdrawn before ack, then a spurious ack in IDLE.
    irq = 4'b0001;
    wait_int(1'b0, 10, cyc);
    check("drop_int_lo", {7'd0, cyc <= 4}, 8'd1);
    irq = 4'b0000;
    wait_int(1'b1, 10, cyc);
    check("drop_int_hi", {7'd0, cyc <= 5}, 8'd1);
    ack(v, oe);
    check("spur_idle_oe", {7'd0, oe}, 8'd0);
    check("spur_idle_int", {7'd0, bus.INT}, 8'd1);

    // ED,00,4D is not RETI; spurious ack in SERVICE; EOI by STAT write.
    irq = 4'b0001;
    wait_int(1'b0, 10, cyc);
    ack(v, oe);
    check("s0_vec", v, 8'hA0);
    irq = 4'b0000;
    fetch(8'hED);
    fetch(8'h00);
    fetch(8'h4D);
    rd_chk("no_reti_stat", 8'h16, 8'h80);
    ack(v, oe);
    check("spur_svc_oe", {7'd0, oe}, 8'd0);
    io_wr(8'h16, 8'h00);
    rd_chk("eoi_stat", 8'h16, 8'h00);
    io_wr(8'h16, 8'h00);
    rd_chk("eoi_idle_stat", 8'h16, 8'h00);
    check("eoi_idle_int", {7'd0, bus.INT}, 8'd1);

    // Reset in the middle of a driven acknowledge.
    irq = 4'b0100;
    wait_int(1'b0, 10, cyc);
    bus.M1 = 1'b0;
    tick(1);
    bus.IORQ = 1'b0;
    cyc = 0;
    for (int i = 0; i < 8 && !bus.D_OE; i++) begin tick(1); cyc++; end
    check("rst_ack_oe", {7'd0, bus.D_OE}, 8'd1);
    check("rst_ack_vec", bus.D_OUT, 8'hA4);
    res_n = 1'b0;
    #2;
    check("rst_mid_oe", {7'd0, bus.D_OE}, 8'd0);
    check("rst_mid_int", {7'd0, bus.INT}, 8'd1);
    check("rst_mid_dout", bus.D_OUT, 8'h00);
    bus.IORQ = 1'b1; bus.M1 = 1'b1; irq = 4'b0000;
    tick(2);
    res_n = 1'b1;
    tick(3);
    rd_chk("rst2_vec", 8'h14, 8'h00);
    rd_chk("rst2_mask", 8'h15, 8'h00);
    rd_chk("rst2_stat", 8'h16, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
